// File: rtl/fetch_seq_pkg.sv
// Shared types and word-geometry constants for the fetch byte sequencer.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    LAST,
    RESP
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned MEM_RD_LAT     = 1;

endpackage

// File: rtl/byte_word_assembler.sv
// Collects bytes into a registered big-endian word; lane 0 is the most
// significant byte. Lanes not being written keep their value.
module byte_word_assembler
  import fetch_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_en,
  input  logic [1:0]        lane,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word
);

  // Write the incoming byte into its lane when capture is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else begin
      for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
        if (cap_en && (lane == 2'(i))) begin
          word[WORD_W-1-BYTE_W*i -: BYTE_W] <= byte_in;
        end
      end
    end
  end

endmodule

// File: rtl/fetch_byte_sequencer.sv
// Owns the byte-wide instruction memory port: assembles 32-bit fetches from
// four byte reads and interleaves loader byte writes with bounded starvation.
module fetch_byte_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              fetch_req_valid,
  output logic              fetch_req_ready,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_rsp_valid,
  input  logic              fetch_rsp_ready,
  output logic [31:0]       fetch_instr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  state_t            state, state_nxt;
  logic [1:0]        k, k_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_nxt;
  logic              fetch_waiting;
  logic              wr_grant;
  logic              accept;
  logic              cap_en;
  logic [1:0]        cap_lane;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^{fetch_pc[31:ADDR_W], fetch_pc[1:0]};

  // Arbitration: a waiting fetch blocks writes once the starvation limit is hit.
  always_comb begin
    fetch_waiting = fetch_req_valid && (state == IDLE) && !flush;
    wr_grant      = rst_n && wr_valid && ((state == IDLE) || (state == RESP)) &&
                    !(fetch_waiting && (starve_cnt == CNT_W'(STARVE_LIMIT)));
    accept        = rst_n && fetch_waiting && !wr_grant;
  end

  // Next-state, memory port and handshake outputs.
  always_comb begin
    state_nxt       = state;
    k_nxt           = k;
    base_nxt        = base;
    starve_nxt      = starve_cnt;
    fetch_req_ready = 1'b0;
    fetch_rsp_valid = 1'b0;
    wr_ready        = 1'b0;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    busy            = 1'b0;
    cap_en          = 1'b0;
    // Byte k-1 returns the cycle after its issue; in LAST k has wrapped to 0,
    // so the same subtraction yields lane 3.
    cap_lane        = k - 2'd1;

    unique case (state)
      IDLE: begin
        if (accept) begin
          fetch_req_ready = 1'b1;
          base_nxt        = {fetch_pc[ADDR_W-1:2], 2'b00};
          starve_nxt      = '0;
          k_nxt           = 2'd0;
          state_nxt       = ISSUE;
        end
      end
      ISSUE: begin
        busy     = 1'b1;
        mem_en   = 1'b1;
        mem_addr = base + ADDR_W'(k);
        cap_en   = (k != 2'd0) && !flush;
        k_nxt    = k + 2'd1;
        if (flush) begin
          state_nxt = IDLE;
        end else if (k == 2'd3) begin
          state_nxt = LAST;
        end
      end
      LAST: begin
        busy      = 1'b1;
        cap_en    = !flush;
        state_nxt = flush ? IDLE : RESP;
      end
      RESP: begin
        fetch_rsp_valid = 1'b1;
        if (flush || fetch_rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (wr_grant) begin
      wr_ready   = 1'b1;
      mem_en     = 1'b1;
      mem_we     = 1'b1;
      mem_addr   = wr_addr;
      mem_wdata  = wr_data;
      starve_nxt = fetch_waiting ? starve_cnt + 1'b1 : '0;
    end
  end

  // State, byte counter, fetch base and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      base       <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      k          <= k_nxt;
      base       <= base_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  byte_word_assembler u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .cap_en  (cap_en),
    .lane    (cap_lane),
    .byte_in (mem_rdata),
    .word    (fetch_instr)
  );

endmodule

// File: tb/tb_fetch_byte_sequencer.sv
// Bench for fetch_byte_sequencer: byte memory model, transaction-level
// reference model, arbitration vector table and directed corner sequences.
module tb_fetch_byte_sequencer;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        fetch_req_valid;
  logic        fetch_req_ready;
  logic [31:0] fetch_pc;
  logic        fetch_rsp_valid;
  logic        fetch_rsp_ready;
  logic [31:0] fetch_instr;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          pending = 0;
  int          wg = 0;
  logic [15:0] exp_base;
  logic [31:0] exp_word;

  typedef struct {
    logic wr, fr, fl;
    logic wr_rdy, fr_rdy, en, we;
  } vec_t;
  vec_t vecs [7];

  fetch_byte_sequencer #(.ADDR_W(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_pc(fetch_pc), .fetch_rsp_valid(fetch_rsp_valid),
    .fetch_rsp_ready(fetch_rsp_ready), .fetch_instr(fetch_instr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Byte memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: a fetch accepted in cycle t is busy for t+1..t+5,
  // responds from t+6 with the four bytes the model memory held at accept.
  task automatic monitor();
    bit waiting, exp_grant, exp_acc, in_resp;
    int age;
    cyc++;
    if (!rst_n) begin
      pending = 0;
      wg = 0;
      return;
    end
    age     = cyc - acc_cyc;
    in_resp = pending && (age >= 6);
    chk_eq("busy", busy, pending && !in_resp);
    chk_eq("rsp_valid", fetch_rsp_valid, in_resp);
    waiting   = !pending && fetch_req_valid && !flush;
    exp_grant = wr_valid && (!pending || in_resp) && !(waiting && wg == STARVE);
    exp_acc   = waiting && !exp_grant;
    chk_eq("wr_ready", wr_ready, exp_grant);
    chk_eq("fetch_req_ready", fetch_req_ready, exp_acc);
    if (wr_ready) begin
      chk_eq("write_port", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, wr_addr, wr_data});
      ref_mem[wr_addr] = wr_data;
      wg = waiting ? wg + 1 : 0;
    end
    if (pending && age >= 1 && age <= 4)
      chk_eq("issue_port", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, exp_base + 16'(age - 1)});
    if (pending && age == 5) chk_eq("last_no_access", mem_en, 1'b0);
    if (!pending && !wr_ready) chk_eq("idle_no_access", mem_en, 1'b0);
    if (in_resp) chk_eq("rsp_word", fetch_instr, exp_word);
    if (pending && (flush || (in_resp && fetch_rsp_ready))) pending = 0;
    if (fetch_req_ready) begin
      exp_base = {fetch_pc[15:2], 2'b00};
      exp_word = {ref_mem[exp_base], ref_mem[exp_base + 16'd1],
                  ref_mem[exp_base + 16'd2], ref_mem[exp_base + 16'd3]};
      pending  = 1;
      acc_cyc  = cyc;
      wg       = 0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  task automatic write_byte(input logic [15:0] a, input logic [7:0] d);
    bit got = 0;
    wr_valid = 1; wr_addr = a; wr_data = d;
    for (int n = 0; n < 10 && !got; n++) begin
      sample();
      got = wr_ready;
      tick();
    end
    wr_valid = 0;
    chk_eq("preload_grant", got, 1'b1);
  endtask

  // Leaves the bench at cycle t+1 after an accept in cycle t.
  task automatic accept_fetch(input logic [31:0] pc, output bit got);
    got = 0;
    fetch_pc = pc; fetch_req_valid = 1;
    for (int n = 0; n < 20 && !got; n++) begin
      sample();
      got = fetch_req_ready;
      tick();
    end
    fetch_req_valid = 0;
    chk_eq("accept_timeout", got, 1'b1);
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] exp, input string tag);
    bit got;
    logic [15:0] ea;
    fetch_rsp_ready = 1;
    accept_fetch(pc, got);
    if (got) begin
      for (int k = 0; k < 4; k++) begin
        ea = {pc[15:2], 2'b00} + 16'(k);
        sample();
        chk_eq({tag, "_addr"}, {mem_en, mem_addr}, {1'b1, ea});
        tick();
      end
      step();
      sample();
      chk_eq({tag, "_valid"}, fetch_rsp_valid, 1'b1);
      chk_eq({tag, "_instr"}, fetch_instr, exp);
      tick();
      sample();
      chk_eq({tag, "_valid_drop"}, fetch_rsp_valid, 1'b0);
      tick();
    end
  endtask

  initial begin
    bit got;
    int grants;
    logic [31:0] held;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 0; flush = 0; fetch_req_valid = 0; fetch_pc = '0; fetch_rsp_ready = 0;
    wr_valid = 1; wr_addr = 16'h0055; wr_data = 8'h66;
    repeat (2) @(posedge clk);
    sample();
    chk_eq("reset_outputs", {fetch_instr, fetch_rsp_valid, fetch_req_ready, wr_ready, mem_en, mem_we, busy},
           {32'h0, 6'b0});
    chk_eq("reset_mem_port", {mem_addr, mem_wdata}, 24'h0);
    wr_valid = 0;
    tick();
    rst_n = 1;

    for (int a = 0; a < 64; a++) write_byte(16'(a), 8'($urandom));
    write_byte(16'h0010, 8'h00); write_byte(16'h0011, 8'h50);
    write_byte(16'h0012, 8'h00); write_byte(16'h0013, 8'h93);
    write_byte(16'hFFFC, 8'hDE); write_byte(16'hFFFD, 8'hAD);
    write_byte(16'hFFFE, 8'hBE); write_byte(16'hFFFF, 8'hEF);

    // Arbitration table from IDLE.
    fetch_pc = 32'h0000_0020;
    for (int i = 0; i < 7; i++) begin
      wr_valid = vecs[i].wr; fetch_req_valid = vecs[i].fr; flush = vecs[i].fl;
      wr_addr = 16'h0200 + 16'(i); wr_data = 8'h30 + 8'(i);
      sample();
      chk_eq($sformatf("vec%0d_grants", i), {wr_ready, fetch_req_ready, mem_en, mem_we},
             {vecs[i].wr_rdy, vecs[i].fr_rdy, vecs[i].en, vecs[i].we});
      if (vecs[i].en) chk_eq($sformatf("vec%0d_addr", i), mem_addr, 16'h0200 + 16'(i));
      got = fetch_req_ready;
      tick();
      wr_valid = 0; fetch_req_valid = 0; flush = 0;
      if (got) begin
        flush = 1;
        sample(); chk_eq($sformatf("vec%0d_busy", i), busy, 1'b1); tick();
        flush = 0;
        sample(); chk_eq($sformatf("vec%0d_flushed", i), busy, 1'b0); tick();
      end
    end

    do_fetch(32'h0000_0012, 32'h0050_0093, "basic");

    // Backpressure with a write granted during RESP.
    fetch_rsp_ready = 0;
    accept_fetch(32'h0000_0012, got);
    repeat (5) step();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin wr_valid = 1; wr_addr = 16'h0100; wr_data = 8'hAA; end
      sample();
      chk_eq("bp_valid", fetch_rsp_valid, 1'b1);
      chk_eq("bp_instr", fetch_instr, 32'h0050_0093);
      if (i == 2) chk_eq("bp_resp_write", wr_ready, 1'b1);
      tick();
      wr_valid = 0;
    end
    fetch_rsp_ready = 1; fetch_req_valid = 1; fetch_pc = 32'h0000_0010;
    sample(); chk_eq("bp_no_accept_in_handshake", fetch_req_ready, 1'b0); tick();
    sample(); chk_eq("bp_accept_next", fetch_req_ready, 1'b1); tick();
    fetch_req_valid = 0;
    repeat (8) step();
    chk_eq("bp_mem_written", mem[16'h0100], 8'hAA);

    // Starvation: writes and fetch held together.
    wr_valid = 1; wr_addr = 16'h0300; wr_data = 8'h5A;
    fetch_req_valid = 1; fetch_pc = 32'h0000_0010; fetch_rsp_ready = 0;
    grants = 0; got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      sample();
      if (wr_ready) grants++;
      got = fetch_req_ready;
      tick();
    end
    fetch_req_valid = 0;
    chk_eq("starve_grants", grants, STARVE);
    chk_eq("starve_accept", got, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      sample(); chk_eq($sformatf("starve_wr_refused_t%0d", i), wr_ready, 1'b0); tick();
    end
    sample();
    chk_eq("starve_rsp", {fetch_rsp_valid, wr_ready, fetch_instr}, {2'b11, 32'h0050_0093});
    tick();
    wr_valid = 0; fetch_rsp_ready = 1;
    step();
    sample(); chk_eq("starve_done", fetch_rsp_valid, 1'b0); tick();

    // Flush at t+3.
    accept_fetch(32'h0000_0010, got);
    step(); step();
    flush = 1;
    step();
    flush = 0;
    sample();
    chk_eq("flush_idle", {busy, mem_en, fetch_rsp_valid}, 3'b000);
    tick();
    for (int i = 0; i < 8; i++) begin
      sample(); chk_eq("flush_no_rsp", fetch_rsp_valid, 1'b0); tick();
    end
    do_fetch(32'h0000_0010, 32'h0050_0093, "post_flush");

    do_fetch(32'h0001_FFFE, 32'hDEAD_BEEF, "wrap");

    // Asynchronous reset during ISSUE.
    accept_fetch(32'h0000_0010, got);
    step();
    #2;
    rst_n = 0; wr_valid = 1;
    #1;
    chk_eq("areset_outputs", {fetch_instr, fetch_rsp_valid, fetch_req_ready, wr_ready, mem_en, mem_we, busy},
           {32'h0, 6'b0});
    chk_eq("areset_addr", mem_addr, 16'h0);
    wr_valid = 0;
    step(); step();
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      sample(); chk_eq("areset_no_stale", {fetch_rsp_valid, busy}, 2'b00); tick();
    end
    do_fetch(32'h0000_0010, 32'h0050_0093, "post_reset");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      wr_valid        = ($urandom_range(0, 99) < 30);
      wr_addr         = 16'($urandom_range(0, 63));
      wr_data         = 8'($urandom);
      fetch_req_valid = ($urandom_range(0, 99) < 50);
      fetch_pc        = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 63));
      fetch_rsp_ready = ($urandom_range(0, 99) < 60);
      flush           = ($urandom_range(0, 99) < 5);
      step();
    end
    wr_valid = 0; fetch_req_valid = 0; flush = 0; fetch_rsp_ready = 1;
    repeat (10) step();
    for (int a = 0; a < 64; a++) chk_eq("final_mem", mem[a], ref_mem[a]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_byte_sequencer.md
Name: fetch_byte_sequencer

Overview:
- Owns the single port of the byte-wide, 64 KiB instruction memory.
- Serves two requesters:
  - the core's fetch stage, which reads one 32-bit word per request;
  - the program loader / debug port, which writes single bytes.
- For a fetch, it issues four byte reads and assembles them big-endian: the byte at the base address lands in [31:23+1], i.e. [31:24].
- It returns the word over a valid/ready handshake and arbitrates loader writes against pending fetches with bounded starvation.

Parameters:
- ADDR_W, 16: byte-address width of the memory.
- STARVE_LIMIT, 4: maximum consecutive write grants while a fetch request waits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  abandons any in-flight or pending fetch (branch/redirect).
- fetch_req_valid  in  1  fetch request.
- fetch_req_ready  out  1  request accepted this cycle.
- fetch_pc  in  32  fetch address; bits [1:0] and [31:ADDR_W] are ignored.
- fetch_rsp_valid  out  1  fetch_instr is valid.
- fetch_rsp_ready  in  1  consumer takes the response.
- fetch_instr  out  32  assembled instruction word.
- wr_valid  in  1  loader byte-write request.
- wr_ready  out  1  write granted this cycle.
- wr_addr  in  ADDR_W  byte address to write.
- wr_data  in  8  byte to write.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable (meaningful only with mem_en).
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data, valid exactly one cycle after a read strobe.
- busy  out  1  high in ISSUE or LAST.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, starve_cnt=0, base=0, fetch_instr=0;
  - fetch_rsp_valid, wr_ready, fetch_req_ready, mem_en, mem_we, busy all 0; mem_addr, mem_wdata 0.
  - Reset mid-fetch discards the fetch; no response is produced.
- States: IDLE, ISSUE (byte counter k=0..3), LAST, RESP.
- IDLE / RESP arbitration (combinational grant):
  - Write grant condition: wr_valid && !(fetch_req_valid && state==IDLE && !flush && starve_cnt==STARVE_LIMIT).
  - On a write grant: wr_ready=1, mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data; the write completes that cycle.
  - starve_cnt increments if a fetch request was waiting in IDLE during the grant, otherwise clears.
- Fetch accept: in IDLE with no write grant, fetch_req_valid=1 and flush=0:
  - fetch_req_ready=1;
  - base <= {fetch_pc[ADDR_W-1:2],2'b00}; starve_cnt <= 0; next state ISSUE, k=0.
- ISSUE (cycles t+1..t+4, where t is the accept cycle):
  - mem_en=1, mem_we=0, mem_addr=base+k; k increments each cycle; after k=3 go to LAST.
  - Byte k is captured from mem_rdata in the cycle after its issue into lane [31-8k -: 8].
- LAST (cycle t+5): captures byte 3, no memory access, then RESP.
- RESP (from cycle t+6): fetch_rsp_valid=1 and fetch_instr is held stable until fetch_rsp_ready=1; then go to IDLE.
- Latency and throughput:
  - Accept to rsp_valid is 6 cycles.
  - The next fetch is accepted at the earliest in the cycle after the response handshake.
- Writes are refused (wr_ready=0) in ISSUE and LAST.
- flush:
  - In ISSUE or LAST: next state IDLE; the read already issued is ignored; fetch_instr is left unchanged; no response.
  - In RESP: fetch_rsp_valid drops next cycle and state goes to IDLE, even if fetch_rsp_ready was high. flush wins over the handshake.
  - In IDLE: fetch_req_ready=0; write arbitration is unaffected.
- Address arithmetic:
  - base is word-aligned, so base+k never carries out of bits [1:0].
  - pc above the memory size aliases by truncation.
- Any byte not being captured leaves its lane unchanged.

Decomposition:
- Package fetch_seq_pkg holds:
  - state enum (IDLE, ISSUE, LAST, RESP);
  - BYTES_PER_WORD=4, BYTE_W=8, WORD_W=32, MEM_RD_LAT=1.
- One sub-module, byte_word_assembler: capture enable plus 2-bit lane index to a registered 32-bit big-endian word, with async active-low clear.
- FSM, arbiter and starve counter stay in the top module.

Test Plan:
- Fetch: memory bytes 0x0010..0x0013 = 00,50,00,93; fetch_pc=0x00000012; rsp_ready=1.
  - Expect mem_addr sequence 0x0010..0x0013 in cycles t+1..t+4.
  - Expect fetch_instr=0x00500093 with rsp_valid high in cycle t+6, held for one cycle.
- Backpressure: same fetch with rsp_ready=0 for 5 cycles.
  - rsp_valid and fetch_instr stay stable throughout.
  - A write (wr_addr=0x0100, wr_data=0xAA) during RESP is granted; memory[0x0100]=0xAA.
  - After the handshake, the next accept occurs no earlier than the following cycle.
- Starvation: wr_valid and fetch_req_valid both held high in IDLE.
  - Exactly 4 write grants, then fetch_req_ready=1.
  - wr_ready stays 0 for cycles t+1..t+5.
- Flush: assert flush in cycle t+3 of a fetch.
  - Expect IDLE at t+4, no rsp_valid ever, and mem_en=0 at t+4 unless a write is granted.
  - A subsequent fetch of 0x0010 returns 0x00500093.
- Wrap: fetch_pc=0x0001FFFE (ADDR_W=16).
  - Expect mem_addr 0xFFFC..0xFFFF and a word assembled from those bytes.
- Reset: rst_n pulled low mid-ISSUE asynchronously.
  - All outputs go to 0 immediately; after release, state is IDLE and no stale response appears.
